// File: rtl/bsg_round_robin_n_to_1_buffered.sv
// Re-merges num_in_p buffered lanes into one stream in strict round-robin lane order.
// Optional sticky handshake checker: define BSG_ROUND_ROBIN_N_TO_1_PROTOCOL_CHECK_EN.
module bsg_round_robin_n_to_1_buffered #(
    parameter int width_p  = 32,
    parameter int num_in_p = 8,
    parameter int els_p    = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [num_in_p*width_p-1:0]   data_i,
    input  logic [num_in_p-1:0]           valid_i,
    output logic [num_in_p-1:0]           ready_o,
    output logic [width_p-1:0]            data_o,
    output logic                          valid_o,
    input  logic                          yumi_i,
    output logic [$clog2(num_in_p)-1:0]   lane_o,
    output logic                          protocol_err_o
);
    localparam int lg_n_lp  = $clog2(num_in_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int idx_w_lp = $clog2(els_p);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp  = cnt_w_lp'(els_p);
    localparam logic [idx_w_lp-1:0] last_idx_lp  = idx_w_lp'(els_p - 1);
    localparam logic [lg_n_lp-1:0]  last_lane_lp = lg_n_lp'(num_in_p - 1);

    logic [width_p-1:0]  r_mem    [num_in_p][els_p];
    logic [idx_w_lp-1:0] r_rd_idx [num_in_p];
    logic [idx_w_lp-1:0] r_wr_idx [num_in_p];
    logic [cnt_w_lp-1:0] r_count  [num_in_p];
    logic [lg_n_lp-1:0]  r_ptr;
    logic                r_live;
    logic [num_in_p-1:0] w_enq;
    logic [num_in_p-1:0] w_deq;
    logic                w_pop;

    function automatic logic [idx_w_lp-1:0] f_next_idx(input logic [idx_w_lp-1:0] i);
        return (i == last_idx_lp) ? '0 : i + 1'b1;
    endfunction

    // Handshakes: a lane word transfers when valid_i[k] & ready_o[k] at a rising edge; the output
    // word transfers when yumi_i is high, which the consumer may only assert while valid_o is high.
    // r_live holds ready_o low until the first edge after reset release, so ready_o is state-only.
    assign valid_o = (r_count[r_ptr] != '0);
    assign data_o  = r_mem[r_ptr][r_rd_idx[r_ptr]];
    assign lane_o  = r_ptr;
    assign w_pop   = yumi_i & valid_o;

    always_comb begin
        ready_o = '0;
        w_enq   = '0;
        w_deq   = '0;
        for (int k = 0; k < num_in_p; k++) begin
            ready_o[k] = r_live & (r_count[k] != full_cnt_lp);
            w_enq[k]   = valid_i[k] & ready_o[k];
            w_deq[k]   = w_pop & (r_ptr == lg_n_lp'(k));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_live <= 1'b0;
            r_ptr  <= '0;
            for (int k = 0; k < num_in_p; k++) begin
                r_count[k]  <= '0;
                r_rd_idx[k] <= '0;
                r_wr_idx[k] <= '0;
            end
        end else begin
            r_live <= 1'b1;
            if (w_pop) begin
                r_ptr <= (r_ptr == last_lane_lp) ? '0 : r_ptr + 1'b1;
            end
            for (int k = 0; k < num_in_p; k++) begin
                if (w_enq[k]) r_wr_idx[k] <= f_next_idx(r_wr_idx[k]);
                if (w_deq[k]) r_rd_idx[k] <= f_next_idx(r_rd_idx[k]);
                case ({w_enq[k], w_deq[k]})
                    2'b10:   r_count[k] <= r_count[k] + 1'b1;
                    2'b01:   r_count[k] <= r_count[k] - 1'b1;
                    default: r_count[k] <= r_count[k];
                endcase
            end
        end
    end

    // Storage needs no reset: counts gate everything that is ever presented.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < num_in_p; k++) begin
            if (w_enq[k]) r_mem[k][r_wr_idx[k]] <= data_i[k*width_p +: width_p];
        end
    end

`ifdef BSG_ROUND_ROBIN_N_TO_1_PROTOCOL_CHECK_EN
    logic                r_err;
    logic [num_in_p-1:0] r_stall;
    logic [width_p-1:0]  r_stall_data [num_in_p];
    logic                w_violation;

    // A lane offered but refused last cycle must hold valid and data until accepted.
    always_comb begin
        w_violation = yumi_i & ~valid_o;
        for (int k = 0; k < num_in_p; k++) begin
            if (r_stall[k] & (~valid_i[k] | (data_i[k*width_p +: width_p] != r_stall_data[k]))) begin
                w_violation = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err   <= 1'b0;
            r_stall <= '0;
            for (int k = 0; k < num_in_p; k++) r_stall_data[k] <= '0;
        end else begin
            r_err   <= r_err | w_violation;
            r_stall <= valid_i & ~ready_o;
            for (int k = 0; k < num_in_p; k++) r_stall_data[k] <= data_i[k*width_p +: width_p];
        end
    end

    assign protocol_err_o = r_err;
`else
    assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_round_robin_n_to_1_buffered.sv
// Bench for bsg_round_robin_n_to_1_buffered: vector table, directed corner sequences,
// and a random in-order scoreboard phase; a 3-lane instance covers non power-of-two lane counts.
module tb_bsg_round_robin_n_to_1_buffered;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int N3 = 3;
`ifdef BSG_ROUND_ROBIN_N_TO_1_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N*W-1:0]  data_i;
  logic [N-1:0]    valid_i;
  logic [N-1:0]    ready_o;
  logic [W-1:0]    data_o;
  logic            valid_o;
  logic            yumi_i;
  logic [2:0]      lane_o;
  logic            err_o;

  logic [N3*W-1:0] data3_i;
  logic [N3-1:0]   valid3_i;
  logic [N3-1:0]   ready3_o;
  logic [W-1:0]    data3_o;
  logic            valid3_o;
  logic            yumi3_i;
  logic [1:0]      lane3_o;
  logic            err3_o;

  bsg_round_robin_n_to_1_buffered #(.width_p(W), .num_in_p(N), .els_p(2)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .yumi_i(yumi_i), .lane_o(lane_o), .protocol_err_o(err_o)
  );

  bsg_round_robin_n_to_1_buffered #(.width_p(W), .num_in_p(N3), .els_p(2)) u_dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(data3_i), .valid_i(valid3_i), .ready_o(ready3_o),
    .data_o(data3_o), .valid_o(valid3_o), .yumi_i(yumi3_i), .lane_o(lane3_o), .protocol_err_o(err3_o)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];

  typedef struct packed {
    logic [N-1:0] vin;
    logic [7:0]   dbase;
    logic         yumi;
    logic         exp_v;
    logic [W-1:0] exp_d;
    logic [2:0]   exp_lane;
    logic [N-1:0] exp_rdy;
    logic         chk_d;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i  = '0;
    yumi_i   = 1'b0;
    valid3_i = '0;
    yumi3_i  = 1'b0;
  endtask

  task automatic set_lanes(input logic [N-1:0] vin, input logic [7:0] dbase);
    valid_i = vin;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = 32'(dbase) + 32'(k);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic pop_check(input string name, input logic [2:0] exp_lane);
    logic [W-1:0] e;
    check({name, " valid_o"}, 64'(valid_o), 64'(1'b1));
    check({name, " lane_o"}, 64'(lane_o), 64'(exp_lane));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got data %0h expected nothing queued", name, data_o);
    end else begin
      e = exp_q.pop_front();
      check({name, " data_o"}, 64'(data_o), 64'(e));
    end
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic [N-1:0] vin, input logic [7:0] dbase, input logic yumi,
                              input logic ev, input logic [W-1:0] ed, input logic [2:0] el,
                              input logic [N-1:0] erdy, input logic chk_d);
    vec_t v;
    v.vin = vin; v.dbase = dbase; v.yumi = yumi; v.exp_v = ev; v.exp_d = ed;
    v.exp_lane = el; v.exp_rdy = erdy; v.chk_d = chk_d;
    return v;
  endfunction

  initial begin
    int fp;
    int el;
    logic [W-1:0] d;
    logic [W-1:0] e;

    // expectations in each row describe the outputs before that row's inputs are applied
    vecs.push_back(mk(8'hFF, 8'hA0, 1'b0, 1'b0, 32'h0, 3'd0, 8'hFF, 1'b0));
    for (int i = 0; i < N; i++)
      vecs.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1, 32'hA0 + 32'(i), 3'(i), 8'hFF, 1'b1));
    vecs.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 3'd0, 8'hFF, 1'b0));
    vecs.push_back(mk(8'h08, 8'h30, 1'b0, 1'b0, 32'h0, 3'd0, 8'hFF, 1'b0));
    vecs.push_back(mk(8'h08, 8'h40, 1'b0, 1'b0, 32'h0, 3'd0, 8'hFF, 1'b0));
    vecs.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 3'd0, 8'hF7, 1'b0));
    vecs.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 3'd0, 8'hF7, 1'b0));
    vecs.push_back(mk(8'h07, 8'h60, 1'b0, 1'b0, 32'h0, 3'd0, 8'hF7, 1'b0));
    vecs.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1, 32'h60, 3'd0, 8'hF7, 1'b1));
    vecs.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1, 32'h61, 3'd1, 8'hF7, 1'b1));
    vecs.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1, 32'h62, 3'd2, 8'hF7, 1'b1));
    vecs.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1, 32'h33, 3'd3, 8'hF7, 1'b1));
    vecs.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 3'd4, 8'hFF, 1'b0));

    data_i  = '0;
    data3_i = '0;
    clear_inputs();
    reset_n = 1'b0;
    #1;
    check("reset ready_o", 64'(ready_o), 64'(8'h00));
    check("reset valid_o", 64'(valid_o), 64'(1'b0));
    step();
    reset_n = 1'b1;
    step();
    check("post-reset ready_o", 64'(ready_o), 64'(8'hFF));
    check("post-reset lane_o", 64'(lane_o), 64'(0));
    check("post-reset err", 64'(err_o), 64'(1'b0));

    // in-order merge and head-of-line blocking
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d valid_o", i), 64'(valid_o), 64'(vecs[i].exp_v));
      check($sformatf("vec%0d lane_o", i), 64'(lane_o), 64'(vecs[i].exp_lane));
      check($sformatf("vec%0d ready_o", i), 64'(ready_o), 64'(vecs[i].exp_rdy));
      if (vecs[i].chk_d) check($sformatf("vec%0d data_o", i), 64'(data_o), 64'(vecs[i].exp_d));
      set_lanes(vecs[i].vin, vecs[i].dbase);
      yumi_i = vecs[i].yumi;
      step();
    end
    clear_inputs();

    // mid-traffic reset: lane 3 still holds a word
    reset_n = 1'b0;
    #1;
    check("midreset ready_o", 64'(ready_o), 64'(8'h00));
    check("midreset valid_o", 64'(valid_o), 64'(1'b0));
    step();
    check("midreset held ready_o", 64'(ready_o), 64'(8'h00));
    reset_n = 1'b1;
    step();
    check("release ready_o", 64'(ready_o), 64'(8'hFF));
    check("release lane_o", 64'(lane_o), 64'(0));
    check("release valid_o", 64'(valid_o), 64'(1'b0));

    // simultaneous enqueue and dequeue on lane 0
    valid_i = 8'h01; data_i[0 +: W] = 32'h11;
    step();
    check("simul pre data_o", 64'(data_o), 64'(32'h11));
    valid_i = 8'h01; data_i[0 +: W] = 32'h55; yumi_i = 1'b1;
    step();
    clear_inputs();
    check("simul lane_o", 64'(lane_o), 64'(1));
    check("simul ready0 count1", 64'(ready_o[0]), 64'(1'b1));
    valid_i = 8'h01; data_i[0 +: W] = 32'h66;
    step();
    clear_inputs();
    check("simul ready0 full", 64'(ready_o[0]), 64'(1'b0));
    set_lanes(8'hFE, 8'h80);
    for (int k = 1; k < N; k++) exp_q.push_back(32'h80 + 32'(k));
    exp_q.push_back(32'h55);
    step();
    clear_inputs();
    for (int k = 1; k < N; k++) pop_check($sformatf("wrap pop%0d", k), 3'(k));
    pop_check("wrap lane0", 3'd0);
    check("wrap end lane_o", 64'(lane_o), 64'(1));
    do_reset();

    // three-lane instance wraps 2 -> 0
    valid3_i = 3'b111;
    for (int k = 0; k < N3; k++) begin
      data3_i[k*W +: W] = 32'hC0 + 32'(k);
      exp3_q.push_back(32'hC0 + 32'(k));
    end
    step();
    for (int k = 0; k < N3; k++) begin
      data3_i[k*W +: W] = 32'hC3 + 32'(k);
      exp3_q.push_back(32'hC3 + 32'(k));
    end
    step();
    valid3_i = '0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("n3 valid %0d", i), 64'(valid3_o), 64'(1'b1));
      check($sformatf("n3 lane %0d", i), 64'(lane3_o), 64'(i % 3));
      e = exp3_q.pop_front();
      check($sformatf("n3 data %0d", i), 64'(data3_o), 64'(e));
      yumi3_i = 1'b1;
      step();
    end
    yumi3_i = 1'b0;
    check("n3 lane after wrap", 64'(lane3_o), 64'(0));
    check("n3 drained", 64'(valid3_o), 64'(1'b0));

    // illegal yumi while nothing is presented
    do_reset();
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    check("illegal yumi lane_o", 64'(lane_o), 64'(0));
    check("illegal yumi err", 64'(err_o), 64'(EXP_ERR));
    step();
    check("illegal yumi err sticky", 64'(err_o), 64'(EXP_ERR));
    check("illegal yumi valid_o", 64'(valid_o), 64'(1'b0));
    do_reset();
    check("err cleared by reset", 64'(err_o), 64'(1'b0));

    // random traffic: lanes fed in round-robin order, so output order equals feed order
    fp = 0;
    el = 0;
    for (int c = 0; c < 300; c++) begin
      clear_inputs();
      check("rand valid_o", 64'(valid_o), 64'(exp_q.size() != 0));
      if (valid_o && exp_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        e = exp_q.pop_front();
        check("rand data_o", 64'(data_o), 64'(e));
        check("rand lane_o", 64'(lane_o), 64'(el));
        el = (el + 1) % N;
        yumi_i = 1'b1;
      end
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 1) == 1 && ready_o[fp]) begin
          d = $urandom;
          data_i[fp*W +: W] = d;
          valid_i[fp] = 1'b1;
          exp_q.push_back(d);
          fp = (fp + 1) % N;
        end else begin
          break;
        end
      end
      step();
    end
    clear_inputs();
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      check("drain valid_o", 64'(valid_o), 64'(1'b1));
      check("drain data_o", 64'(data_o), 64'(e));
      check("drain lane_o", 64'(lane_o), 64'(el));
      el = (el + 1) % N;
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
    end
    check("drain queue empty", 64'(exp_q.size()), 64'(0));
    check("drain valid_o low", 64'(valid_o), 64'(1'b0));
    check("legal traffic err", 64'(err_o), 64'(1'b0));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
